// File: rtl/xor_range_pkg.sv
// Shared opcode and FSM state encodings for the XOR range register file.
package xor_range_pkg;

  typedef enum logic [1:0] {
    OP_XOR_PT = 2'b00,
    OP_WRITE  = 2'b01,
    OP_QUERY  = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/xor_range_regfile_if.sv
// Request/result handshake bundle for the XOR range register file.
interface xor_range_regfile_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    idx_hi;
  logic [WIDTH-1:0] val;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, op, idx, idx_hi, val, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, op, idx, idx_hi, val, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/xor_range_regfile.sv
// DEPTH x WIDTH register file with point XOR/write, bulk clear and a
// multi-cycle range-XOR query that folds one entry per clock.
module xor_range_regfile
  import xor_range_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  xor_range_regfile_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  state_e           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] out_data_r;
  logic             accept;
  op_e              op;
  logic [WIDTH-1:0] fold;

  assign op     = op_e'(bus.op);
  assign accept = bus.in_valid && (state == S_IDLE);
  assign fold   = acc ^ mem[ptr];

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_RESP);
  assign bus.out_data  = out_data_r;

  // Query control: latch range on accept, fold one entry per edge, hold result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      acc        <= '0;
      out_data_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && op == OP_QUERY) begin
            ptr   <= bus.idx;
            // Inclusive count; the AW-bit difference wraps so lo>hi covers the tail then the head
            cnt   <= {1'b0, bus.idx_hi - bus.idx} + (AW+1)'(1);
            acc   <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          acc <= fold;
          ptr <= ptr + AW'(1);
          cnt <= cnt - (AW+1)'(1);
          if (cnt == (AW+1)'(1)) begin
            out_data_r <= fold;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage: updates only land while idle, so a scan always sees a frozen snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      case (op)
        OP_XOR_PT: mem[bus.idx] <= mem[bus.idx] ^ bus.val;
        OP_WRITE:  mem[bus.idx] <= bus.val;
        OP_CLEAR:  for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        default: ;
      endcase
    end
  end

endmodule
